nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq_pkg.sv | 11 +
 rtl/nibble_add_seq_if.sv | 19 +
 rtl/nibble_add_seq_rca4.sv | 23 ++
 rtl/nibble_add_seq.sv | 103 ++++++++++
 tb/tb_nibble_add_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared types and sizes for the nibble-serial add/subtract unit.
package nibble_add_seq_pkg;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int DATA_W  = NIB_W * NUM_NIB;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Operand viewed as an array of nibbles, nibble 0 least significant.
  typedef logic [NUM_NIB-1:0][NIB_W-1:0] nib_vec_t;
endpackage

// File: rtl/nibble_add_seq_if.sv
// Request/result bundle between the requester and the nibble adder.
interface nibble_add_seq_if;
  import nibble_add_seq_pkg::*;

  logic              start;
  logic              op_sub;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              co;
  logic              ovf;

  modport master (output start, op_sub, a, b,
                  input  busy, done, result, co, ovf);
  modport slave  (input  start, op_sub, a, b,
                  output busy, done, result, co, ovf);
endinterface

// File: rtl/nibble_add_seq_rca4.sv
// 4-bit ripple-carry adder: the only adder in the datapath.
module rca4
  import nibble_add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);
  logic c;

  // Ripple the carry bit by bit through full-adder equations.
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial 16-bit add/subtract: one nibble per CALC cycle through a
// single rca4, result published in the DONE cycle.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  nibble_add_seq_if.slave  bus
);
  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              carry_q, carry_d;
  nib_vec_t          a_q, a_d, b_q, b_d, work_q, work_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;

  logic [NIB_W-1:0]  nib_a, nib_b, sum_s;
  logic              sum_co;

  // Select the current nibble of each latched operand.
  assign nib_a = a_q[idx_q];
  assign nib_b = b_q[idx_q];

  rca4 u_rca4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (sum_s),
    .co (sum_co)
  );

  // Next-state and datapath updates; everything holds unless the state acts.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          idx_d   = 2'd0;
          carry_d = bus.op_sub;
          state_d = CALC;
        end
      end
      CALC: begin
        work_d[idx_q] = sum_s;
        carry_d       = sum_co;
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'(NUM_NIB - 1)) begin
          // Top nibble is being produced now, so publish straight from the adder.
          state_d  = DONE;
          result_d = {sum_s, work_q[NUM_NIB-2:0]};
          co_d     = sum_co;
          ovf_d    = (a_q[NUM_NIB-1][NIB_W-1] == b_q[NUM_NIB-1][NIB_W-1]) &&
                     (sum_s[NIB_W-1] != a_q[NUM_NIB-1][NIB_W-1]);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All state, operand, work and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: timeline model plus directed and random traffic.
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  nibble_add_seq_if bus ();

  nibble_add_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference result {ovf, co, result} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] ref_op(logic [15:0] a, logic [15:0] b, logic sub);
    int          sa = $signed(a);
    int          sb = $signed(b);
    int          ua = a;
    int          ub = b;
    int          sr;
    logic [15:0] r;
    logic        c, v;
    sr = sub ? sa - sb : sa + sb;
    r  = sub ? a - b : a + b;
    c  = sub ? (ua >= ub) : (ua + ub > 65535);
    v  = (sr > 32767) || (sr < -32768);
    return {v, c, r};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_cnt is cycles since an accepted start (0 = idle, 5 = done cycle).
  int          m_cnt;
  logic [17:0] m_pend;
  logic [17:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_pend <= '0;
      m_out <= '0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_pend <= ref_op(bus.a, bus.b, bus.op_sub);
        m_cnt  <= 1;
      end
    end else if (m_cnt == 4) begin
      m_out <= m_pend;
      m_cnt <= 5;
    end else if (m_cnt == 5) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Every falling edge the DUT outputs must match the model.
  always @(negedge clk) begin
    chk("busy",   32'(bus.busy),   32'(m_cnt != 0));
    chk("done",   32'(bus.done),   32'(m_cnt == 5));
    chk("result", 32'(bus.result), 32'(m_out[15:0]));
    chk("co",     32'(bus.co),     32'(m_out[16]));
    chk("ovf",    32'(bus.ovf),    32'(m_out[17]));
  end

  // Single directed operation with literal expectations and latency check.
  task automatic run_op(logic [15:0] a, logic [15:0] b, logic sub,
                        logic [15:0] er, logic ec, logic ev);
    int lat;
    chk("model_pin", 32'(ref_op(a, b, sub)), 32'({ev, ec, er}));
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op_sub = sub;
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
      chk("busy_window", 32'(bus.busy), 32'd1);
    end while (!bus.done && lat < 20);
    chk("latency", 32'(lat), 32'd5);
    chk("res_lit", 32'(bus.result), 32'(er));
    chk("co_lit",  32'(bus.co),     32'(ec));
    chk("ovf_lit", 32'(bus.ovf),    32'(ev));
    @(negedge clk);
  endtask

  initial begin
    int dones, last, gap_ok;
    rst = 1'b1;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start pulsed again during CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0100; bus.b = 16'h0200; bus.op_sub = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hABCD; bus.b = 16'h1111; bus.op_sub = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        chk("ignore_res", 32'(bus.result), 32'h0300);
      end
    end
    chk("ignore_dones", 32'(dones), 32'd1);

    // Reset in the 3rd CALC cycle aborts immediately with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h1111; bus.op_sub = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_busy",   32'(bus.busy),   32'd0);
    chk("abort_done",   32'(bus.done),   32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Start held high: one operation every 6 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    last = -1; dones = 0; gap_ok = 1;
    for (int i = 0; i < 40; i++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op_sub = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) begin
        if (last >= 0 && i - last != 6) gap_ok = 0;
        last = i; dones++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("hold_gap",   32'(gap_ok), 32'd1);
    chk("hold_dones", 32'(dones),  32'd6);
    repeat (8) @(negedge clk);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.a      = 16'($urandom);
      bus.b      = 16'($urandom);
      bus.op_sub = 1'($urandom);
      if ($urandom_range(0, 120) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
